// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: pipeline-side requests and memory-bus signals of mem_port_arbiter.
// The arbiter takes the slave view; the environment (pipeline + memory) takes the master view.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_data_o;
  logic        if_ready_o;
  logic        mem_enable_i;
  logic        mem_we_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ready_o;
  logic        stall_o;
  logic        err_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  modport slave (
    input  if_req_i, if_addr_i, mem_enable_i, mem_we_i, mem_addr_i, mem_wdata_i, bus_rdata_i, bus_ack_i,
    output if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, stall_o, err_o,
           bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );
  modport master (
    output if_req_i, if_addr_i, mem_enable_i, mem_we_i, mem_addr_i, mem_wdata_i, bus_rdata_i, bus_ack_i,
    input  if_data_o, if_ready_o, mem_rdata_o, mem_ready_o, stall_o, err_o,
           bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory bus between IF and MEM with req/ack transactions and timeout abort.
// Define STARVE_GUARD_EN to force an IF grant after STARVE_MAX consecutive MEM grants taken while IF waited.
module mem_port_arbiter #(
  parameter int TIMEOUT_CYC = 16
`ifdef STARVE_GUARD_EN
  ,
  parameter int STARVE_MAX = 4
`endif
) (
  input logic              clk,
  input logic              reset_n,
  mem_port_arbiter_if.slave p
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_t;
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] CMAX = CW'(TIMEOUT_CYC - 1);
  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        bus_req_q, bus_req_d, bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
  logic [31:0] if_data_q, if_data_d, mem_rdata_q, mem_rdata_d;
  logic        if_ready_q, if_ready_d, mem_ready_q, mem_ready_d, err_q, err_d;
  logic        force_if, grant_mem, grant_if, busy, tmo, fin;
`ifdef STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
  logic [SW-1:0] stv_q, stv_d;
  assign force_if = p.if_req_i && stv_q == SMAX;
  assign stv_d = grant_if ? '0 : !grant_mem ? stv_q : !p.if_req_i ? '0 : stv_q == SMAX ? stv_q : stv_q + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stv_q <= '0;
    else stv_q <= stv_d;
`else
  assign force_if = 1'b0;
`endif
  assign busy = state_q != IDLE;
  assign tmo = busy && !p.bus_ack_i && cnt_q == CMAX;
  assign fin = busy && (p.bus_ack_i || tmo);
  assign grant_mem = state_q == IDLE && p.mem_enable_i && !force_if;
  assign grant_if = state_q == IDLE && p.if_req_i && !grant_mem;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_ready_q  <= if_ready_d;
      mem_ready_q <= mem_ready_d;
      err_q       <= err_d;
    end
  // wait counter restarts on every grant and parks at CMAX until the abort lands
  always_comb begin
    state_d = grant_mem ? BUSY_MEM : grant_if ? BUSY_IF : fin ? IDLE : state_q;
    cnt_d = (grant_mem || grant_if) ? '0 : (busy && cnt_q != CMAX) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    bus_req_d   = (grant_mem || grant_if) ? 1'b1 : fin ? 1'b0 : bus_req_q;
    bus_we_d    = grant_mem ? p.mem_we_i : (grant_if || fin) ? 1'b0 : bus_we_q;
    bus_addr_d  = grant_mem ? p.mem_addr_i : grant_if ? p.if_addr_i : bus_addr_q;
    bus_wdata_d = grant_mem ? p.mem_wdata_i : grant_if ? '0 : bus_wdata_q;
    if_ready_d  = fin && state_q == BUSY_IF;
    mem_ready_d = fin && state_q == BUSY_MEM;
    err_d       = tmo;
    if_data_d   = (state_q == BUSY_IF && p.bus_ack_i) ? p.bus_rdata_i : '0;
    mem_rdata_d = (state_q == BUSY_MEM && p.bus_ack_i && !bus_we_q) ? p.bus_rdata_i : '0;
  end
  assign p.bus_req_o   = bus_req_q;
  assign p.bus_we_o    = bus_we_q;
  assign p.bus_addr_o  = bus_addr_q;
  assign p.bus_wdata_o = bus_wdata_q;
  assign p.if_data_o   = if_data_q;
  assign p.mem_rdata_o = mem_rdata_q;
  assign p.if_ready_o  = if_ready_q;
  assign p.mem_ready_o = mem_ready_q;
  assign p.err_o       = err_q;
  assign p.stall_o     = (p.if_req_i & ~if_ready_q) | (p.mem_enable_i & ~mem_ready_q);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, hand sequences and random transactions against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int TMO = 16;
  localparam int SMAX = 4;
`ifdef STARVE_GUARD_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int stv = 0;
  mem_port_arbiter_if bus();
  mem_port_arbiter #(.TIMEOUT_CYC(TMO)) dut (.clk(clk), .reset_n(reset_n), .p(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    bit          ifr;
    bit          memr;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    int          a;
    logic [31:0] exp_data;
    bit          exp_err;
  } vec_t;
  vec_t vt[6];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // MEM wins unless the starvation guard has counted STARVE_MAX MEM grants while IF waited
  function automatic bit model_pick_mem();
    return bus.mem_enable_i && !(STARVE && bus.if_req_i && stv == SMAX);
  endfunction
  task automatic model_update(input bit mem_won, input bit if_waiting);
    stv = !mem_won ? 0 : !if_waiting ? 0 : (stv < SMAX) ? stv + 1 : stv;
  endtask
  // one grant from IDLE: ack in BUSY cycle a (a > TMO means no ack), then check the completion cycle
  task automatic run_grant(input bit exp_mem, input int a, input logic [31:0] rd,
                           input logic [31:0] exp_data, input bit exp_err);
    logic [31:0] ea, ew;
    logic ewe;
    bit other;
    ea = exp_mem ? bus.mem_addr_i : bus.if_addr_i;
    ewe = exp_mem & bus.mem_we_i;
    ew = exp_mem ? bus.mem_wdata_i : 32'h0;
    other = exp_mem ? bus.if_req_i : bus.mem_enable_i;
    model_update(exp_mem, bus.if_req_i);
    tick;
    chk("grant", {bus.bus_req_o, bus.bus_we_o, bus.stall_o, bus.bus_addr_o}, {1'b1, ewe, 1'b1, ea});
    chk("grant_wdata", bus.bus_wdata_o, ew);
    if (exp_mem) begin
      bus.mem_addr_i = $urandom;
      bus.mem_wdata_i = $urandom;
    end else bus.if_addr_i = $urandom;
    for (int k = 1; k <= TMO; k++) begin
      chk("busy", {bus.bus_req_o, bus.if_ready_o, bus.mem_ready_o, bus.err_o, bus.bus_addr_o}, {4'b1000, ea});
      bus.bus_rdata_i = (k == a) ? rd : $urandom;
      bus.bus_ack_i = (k == a);
      tick;
      bus.bus_ack_i = 1'b0;
      if (k == a) break;
    end
    chk("done_ready", {bus.if_ready_o, bus.mem_ready_o}, exp_mem ? 2'b01 : 2'b10);
    chk("done_data", exp_mem ? bus.mem_rdata_o : bus.if_data_o, exp_data);
    chk("done_flags", {bus.err_o, bus.bus_req_o, bus.bus_we_o, bus.stall_o}, {exp_err, 2'b00, other});
    if (exp_mem) bus.mem_enable_i = 1'b0;
    else bus.if_req_i = 1'b0;
  endtask
  initial begin
    bus.if_req_i = 0; bus.if_addr_i = 0; bus.mem_enable_i = 0; bus.mem_we_i = 0;
    bus.mem_addr_i = 0; bus.mem_wdata_i = 0; bus.bus_rdata_i = 0; bus.bus_ack_i = 0;
    vt[0] = '{0, 1, 0, 32'h100, 32'h0, 32'hDEADBEEF, 4, 32'hDEADBEEF, 0};
    vt[1] = '{0, 1, 1, 32'h200, 32'h12345678, 32'hFFFF0000, 1, 32'h0, 0};
    vt[2] = '{1, 0, 0, 32'h80, 32'h0, 32'h11111111, TMO + 1, 32'h0, 1};
    vt[3] = '{1, 0, 0, 32'h44, 32'h0, 32'hCAFEF00D, 2, 32'hCAFEF00D, 0};
    vt[4] = '{0, 1, 0, 32'h300, 32'h0, 32'h0BADF00D, TMO, 32'h0BADF00D, 0};
    vt[5] = '{0, 1, 1, 32'h304, 32'hA5A5A5A5, 32'h22222222, TMO + 1, 32'h0, 1};
    tick;
    bus.bus_ack_i = 1'b1;
    tick;
    chk("reset_outs", {bus.bus_req_o, bus.bus_we_o, bus.if_ready_o, bus.mem_ready_o, bus.err_o, bus.stall_o}, 0);
    chk("reset_data", {bus.bus_addr_o, bus.if_data_o}, 0);
    bus.if_req_i = 1'b1;
    #1 chk("reset_stall", bus.stall_o, 1);
    bus.if_req_i = 1'b0;
    bus.bus_ack_i = 1'b0;
    reset_n = 1'b1;
    tick;
    chk("post_reset_idle", {bus.bus_req_o, bus.if_ready_o, bus.mem_ready_o}, 0);
    for (int i = 0; i < 6; i++) begin
      bus.if_req_i = vt[i].ifr; bus.if_addr_i = vt[i].addr;
      bus.mem_enable_i = vt[i].memr; bus.mem_we_i = vt[i].we;
      bus.mem_addr_i = vt[i].addr; bus.mem_wdata_i = vt[i].wd;
      run_grant(vt[i].memr, vt[i].a, vt[i].rd, vt[i].exp_data, vt[i].exp_err);
      tick;
      chk("vec_pulse_end", {bus.if_ready_o, bus.mem_ready_o, bus.err_o, bus.bus_req_o}, 0);
    end
    bus.mem_enable_i = 1; bus.mem_we_i = 1; bus.mem_addr_i = 32'h200; bus.mem_wdata_i = 32'h12345678;
    bus.if_req_i = 1; bus.if_addr_i = 32'h40;
    run_grant(1, 2, 32'hAAAA5555, 32'h0, 0);
    run_grant(0, 3, 32'h00000055, 32'h00000055, 0);
    tick;
    bus.mem_enable_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 32'h500;
    tick;
    chk("rst_grant", bus.bus_req_o, 1);
    tick;
    reset_n = 1'b0;
    #1 chk("rst_async", {bus.bus_req_o, bus.bus_we_o, bus.mem_ready_o, bus.err_o, bus.bus_addr_o}, 0);
    bus.mem_enable_i = 1'b0;
    tick;
    reset_n = 1'b1;
    bus.bus_rdata_i = 32'h77777777;
    bus.bus_ack_i = 1'b1;
    tick;
    bus.bus_ack_i = 1'b0;
    chk("rst_ack_ignored", {bus.bus_req_o, bus.if_ready_o, bus.mem_ready_o, bus.err_o, bus.mem_rdata_o}, 0);
    stv = 0;
    bus.if_req_i = 1; bus.if_addr_i = 32'h600;
    run_grant(0, 1, 32'h600D600D, 32'h600D600D, 0);
    tick;
    for (int g = 0; g < 6; g++) begin
      bus.mem_enable_i = 1; bus.mem_we_i = 0; bus.mem_addr_i = 32'h1000 + g * 4;
      bus.if_req_i = 1; bus.if_addr_i = 32'h40;
      run_grant(STARVE ? (g != SMAX) : 1'b1, 1, 32'h100 + g, 32'h100 + g, 0);
    end
    if (bus.if_req_i) run_grant(0, 2, 32'h4040, 32'h4040, 0);
    tick;
    bus.bus_ack_i = 1'b1;
    bus.bus_rdata_i = 32'h99999999;
    tick;
    bus.bus_ack_i = 1'b0;
    chk("idle_ack", {bus.bus_req_o, bus.if_ready_o, bus.mem_ready_o, bus.err_o, bus.if_data_o}, 0);
    tick;
    chk("idle_ack_after", bus.bus_req_o, 0);
    for (int n = 0; n < 60; n++) begin
      bit em;
      int a;
      logic [31:0] rd;
      if (!bus.if_req_i && $urandom_range(0, 1) == 1) begin
        bus.if_req_i = 1; bus.if_addr_i = $urandom;
      end
      if (!bus.mem_enable_i && $urandom_range(0, 1) == 1) begin
        bus.mem_enable_i = 1; bus.mem_we_i = $urandom_range(0, 1) == 1;
        bus.mem_addr_i = $urandom; bus.mem_wdata_i = $urandom;
      end
      if (!bus.if_req_i && !bus.mem_enable_i) begin
        bus.bus_ack_i = $urandom_range(0, 1) == 1;
        tick;
        bus.bus_ack_i = 1'b0;
        chk("rnd_idle", {bus.bus_req_o, bus.if_ready_o, bus.mem_ready_o, bus.err_o}, 0);
      end else begin
        em = model_pick_mem();
        a = ($urandom_range(0, 7) == 0) ? TMO + 1 : $urandom_range(1, 6);
        rd = $urandom;
        run_grant(em, a, rd, (a > TMO || (em && bus.mem_we_i)) ? 32'h0 : rd, a > TMO);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
